// File: rtl/led_pattern_ctrl_if.sv
// ============================================================================
// Module      : led_pattern_ctrl_if
// Description : Mode-request handshake bundle (mode, pattern, valid/ready)
//               between a requester and led_pattern_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_pattern_ctrl_if #(
    parameter int LED_NUM = 4
) ();
    logic [1:0]         mode_in;
    logic [LED_NUM-1:0] pattern_in;
    logic               mode_valid;
    logic               mode_ready;

    modport master (
        output mode_in,
        output pattern_in,
        output mode_valid,
        input  mode_ready
    );

    modport slave (
        input  mode_in,
        input  pattern_in,
        input  mode_valid,
        output mode_ready
    );
endinterface

`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
// ============================================================================
// Module      : led_pattern_ctrl
// Description : LED_NUM-wide LED driver with running-light, blink, PWM
//               breathe and static modes selected over a valid/ready request.
//               Define LEDCTRL_ACTIVE_LOW_EN to invert led for active-low LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_ctrl #(
    parameter int LED_NUM     = 4,
    parameter int STEP_CNT    = 12500000,
    parameter int PWM_BITS    = 8,
    parameter int BREATHE_DIV = 195312
) (
    input  wire                 sys_clk,
    input  wire                 rst_n,
    led_pattern_ctrl_if.slave   req,
    input  wire                 pause,
    output logic [1:0]          cur_mode,
    output logic [LED_NUM-1:0]  led
);

    localparam int STEP_W = $clog2(STEP_CNT);
    localparam int BDIV_W = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;

    localparam logic [STEP_W-1:0]   c_step_last = STEP_W'(STEP_CNT - 1);
    localparam logic [BDIV_W-1:0]   c_bdiv_last = BDIV_W'(BREATHE_DIV - 1);
    localparam logic [PWM_BITS-1:0] c_duty_max  = '1;

    localparam logic [1:0] c_mode_run     = 2'd0;
    localparam logic [1:0] c_mode_blink   = 2'd1;
    localparam logic [1:0] c_mode_breathe = 2'd2;
    localparam logic [1:0] c_mode_static  = 2'd3;

`ifdef LEDCTRL_ACTIVE_LOW_EN
    localparam logic [LED_NUM-1:0] c_led_off = '1;
`else
    localparam logic [LED_NUM-1:0] c_led_off = '0;
`endif

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_mode_ready;
    logic [STEP_W-1:0]   r_presc;
    logic [BDIV_W-1:0]   r_bdiv;
    logic [PWM_BITS-1:0] r_pwm;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_dir_up;
    logic                r_phase;
    logic [LED_NUM-1:0]  r_run_pat;
    logic [LED_NUM-1:0]  r_pattern;

    logic                w_step;
    logic                w_btick;
    logic                w_accept;
    logic [LED_NUM-1:0]  w_led_act;

    assign req.mode_ready = r_mode_ready;

    assign w_step   = (r_presc == c_step_last);
    assign w_btick  = (r_bdiv == c_bdiv_last);
    assign w_accept = r_mode_ready & req.mode_valid;

    // Active-high view of the current mode state; led registers this value.
    always_comb begin
        w_led_act = '0;
        case (cur_mode)
            c_mode_run:     w_led_act = r_run_pat;
            c_mode_blink:   w_led_act = {LED_NUM{r_phase}};
            c_mode_breathe: w_led_act = {LED_NUM{(r_pwm < r_duty)}};
            c_mode_static:  w_led_act = r_pattern;
            default:        w_led_act = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_LOAD;
            r_mode_ready <= 1'b0;
            cur_mode     <= c_mode_run;
            r_pattern    <= '0;
            led          <= c_led_off;
            r_presc      <= '0;
            r_bdiv       <= '0;
            r_pwm        <= '0;
            r_duty       <= '0;
            r_dir_up     <= 1'b1;
            r_phase      <= 1'b0;
            r_run_pat    <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    led          <= c_led_off;
                    r_presc      <= '0;
                    r_bdiv       <= '0;
                    r_pwm        <= '0;
                    r_duty       <= '0;
                    r_dir_up     <= 1'b1;
                    r_phase      <= 1'b0;
                    r_run_pat    <= LED_NUM'(1);
                    r_mode_ready <= 1'b1;
                    r_state      <= pause ? S_PAUSE : S_RUN;
                end

                S_RUN: begin
                    led     <= w_led_act ^ c_led_off;
                    r_presc <= w_step ? '0 : r_presc + STEP_W'(1);

                    if (cur_mode == c_mode_run && w_step)
                        r_run_pat <= {r_run_pat[LED_NUM-2:0], r_run_pat[LED_NUM-1]};

                    if (cur_mode == c_mode_blink && w_step)
                        r_phase <= ~r_phase;

                    if (cur_mode == c_mode_breathe) begin
                        r_pwm  <= r_pwm + PWM_BITS'(1);
                        r_bdiv <= w_btick ? '0 : r_bdiv + BDIV_W'(1);
                        // Endpoints spend one extra divider period while only the direction flips.
                        if (w_btick) begin
                            if (r_dir_up) begin
                                if (r_duty == c_duty_max) r_dir_up <= 1'b0;
                                else                      r_duty   <= r_duty + PWM_BITS'(1);
                            end else begin
                                if (r_duty == '0) r_dir_up <= 1'b1;
                                else              r_duty   <= r_duty - PWM_BITS'(1);
                            end
                        end
                    end

                    r_state <= pause ? S_PAUSE : S_RUN;
                end

                S_PAUSE: begin
                    r_state <= pause ? S_PAUSE : S_RUN;
                end

                default: begin
                    r_state      <= S_LOAD;
                    r_mode_ready <= 1'b0;
                end
            endcase

            // Accepting a request overrides pause and any normal state transition.
            if (w_accept) begin
                cur_mode     <= req.mode_in;
                r_pattern    <= req.pattern_in;
                r_mode_ready <= 1'b0;
                r_state      <= S_LOAD;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
// ============================================================================
// Module      : tb_led_pattern_ctrl
// Description : Directed self-checking bench for led_pattern_ctrl
//               (LED_NUM=4, STEP_CNT=4, PWM_BITS=2, BREATHE_DIV=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_ctrl;

`ifdef LEDCTRL_ACTIVE_LOW_EN
    localparam logic [3:0] c_inv = 4'hF;
`else
    localparam logic [3:0] c_inv = 4'h0;
`endif

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       pause   = 1'b0;
    logic [1:0] cur_mode;
    logic [3:0] led;

    int n_tests = 0;
    int n_fail  = 0;

    led_pattern_ctrl_if #(.LED_NUM(4)) req_if ();

    led_pattern_ctrl #(
        .LED_NUM     (4),
        .STEP_CNT    (4),
        .PWM_BITS    (2),
        .BREATHE_DIV (2)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .req      (req_if),
        .pause    (pause),
        .cur_mode (cur_mode),
        .led      (led)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // Accept at edge k, optionally hold valid through the S_LOAD edge (must be ignored).
    task automatic request(input logic [1:0] m, input logic [3:0] p, input bit hold_extra);
        req_if.mode_in    = m;
        req_if.pattern_in = p;
        req_if.mode_valid = 1'b1;
        tick();
        check_val("accept_cur_mode", 32'(cur_mode), 32'(m));
        check_val("accept_ready_low", 32'(req_if.mode_ready), 32'd0);
        if (hold_extra) begin
            req_if.mode_in    = (m == 2'd3) ? 2'd0 : 2'd3;
            req_if.pattern_in = 4'h5;
        end else begin
            req_if.mode_valid = 1'b0;
        end
        tick();
        req_if.mode_valid = 1'b0;
        check_val("load_led_off", 32'(led), 32'(c_inv));
        check_val("load_cur_mode_kept", 32'(cur_mode), 32'(m));
        check_val("post_load_ready", 32'(req_if.mode_ready), 32'd1);
    endtask

    initial begin
        logic [3:0]  e;
        logic [19:0] br_tab;
        logic [3:0]  one_hot;

        br_tab = 20'h01370;
        one_hot = 4'b0001;
        req_if.mode_in    = 2'd0;
        req_if.pattern_in = 4'h0;
        req_if.mode_valid = 1'b0;

        repeat (3) @(negedge sys_clk);
        check_val("reset_led", 32'(led), 32'(c_inv));
        check_val("reset_ready", 32'(req_if.mode_ready), 32'd0);
        check_val("reset_cur_mode", 32'(cur_mode), 32'd0);

        // Reset release: S_LOAD edge, then RUN sequence.
        rst_n = 1'b1;
        tick();
        check_val("first_load_led", 32'(led), 32'(c_inv));
        check_val("first_run_ready", 32'(req_if.mode_ready), 32'd1);
        for (int n = 1; n <= 20; n++) begin
            tick();
            e = one_hot << (((n - 1) / 4) % 4);
            check_val("run_seq", 32'(led), 32'(e ^ c_inv));
        end

        // BLINK, with valid held through the S_LOAD cycle.
        request(2'd1, 4'h0, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            tick();
            e = ((((n - 1) / 4) % 2) != 0) ? 4'hF : 4'h0;
            check_val("blink_seq", 32'(led), 32'(e ^ c_inv));
        end
        check_val("blink_cur_mode", 32'(cur_mode), 32'd1);

        // STATIC 1010 held for 100 cycles.
        request(2'd3, 4'b1010, 1'b0);
        for (int n = 1; n <= 100; n++) begin
            tick();
            check_val("static_led", 32'(led), 32'(4'b1010 ^ c_inv));
        end

        // BREATHE: duty 0,1,2,3,3,2,1,0,0,1 every 2 cycles against a 4-cycle PWM.
        request(2'd2, 4'h0, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            tick();
            e = br_tab[n-1] ? 4'hF : 4'h0;
            check_val("breathe_seq", 32'(led), 32'(e ^ c_inv));
        end

        // RUN, pause at 0100 with prescaler count 1, hold 20 cycles.
        request(2'd0, 4'h0, 1'b0);
        for (int n = 1; n <= 9; n++) begin
            tick();
            e = one_hot << (((n - 1) / 4) % 4);
            check_val("run2_seq", 32'(led), 32'(e ^ c_inv));
        end
        pause = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            check_val("pause_hold", 32'(led), 32'(4'b0100 ^ c_inv));
        end
        check_val("pause_ready", 32'(req_if.mode_ready), 32'd1);
        pause = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            check_val("resume_hold", 32'(led), 32'(4'b0100 ^ c_inv));
        end
        tick();
        check_val("resume_rotate", 32'(led), 32'(4'b1000 ^ c_inv));

        // Accept with pause high: S_LOAD then S_PAUSE, counters frozen until release.
        pause = 1'b1;
        request(2'd2, 4'h0, 1'b0);
        for (int n = 1; n <= 5; n++) begin
            tick();
            check_val("accept_pause_led", 32'(led), 32'(c_inv));
        end
        pause = 1'b0;
        tick();
        check_val("leave_pause_led", 32'(led), 32'(c_inv));
        for (int n = 1; n <= 6; n++) begin
            tick();
            e = br_tab[n-1] ? 4'hF : 4'h0;
            check_val("breathe2_seq", 32'(led), 32'(e ^ c_inv));
        end

        // Asynchronous reset mid-BREATHE, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_led", 32'(led), 32'(c_inv));
        check_val("async_rst_ready", 32'(req_if.mode_ready), 32'd0);
        check_val("async_rst_mode", 32'(cur_mode), 32'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        tick();
        check_val("rerelease_load_led", 32'(led), 32'(c_inv));
        tick();
        check_val("rerelease_run_led", 32'(led), 32'(4'b0001 ^ c_inv));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
